fpu_sched: RTL

FPU_SCHED -- requirements
Module: fpu_sched

---
 rtl/fpu_sched.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/fpu_sched.sv
// Two-channel round-robin scheduler in front of one shared FPU: grants a requester,
// issues its operands, and returns the FPU result, a timeout NaN, or an invalid-op error.
module fpu_sched #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_i,
    input  logic [31:0] a0_i,
    input  logic [31:0] b0_i,
    input  logic [31:0] a1_i,
    input  logic [31:0] b1_i,
    input  logic [1:0]  op0_i,
    input  logic [1:0]  op1_i,
    output logic [1:0]  gnt_o,
    output logic [1:0]  rsp_valid_o,
    output logic [31:0] rsp_r_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    output logic [31:0] fpu_a_o,
    output logic [31:0] fpu_b_o,
    output logic [1:0]  fpu_op_o,
    output logic        fpu_start_o,
    input  logic        fpu_done_i,
    input  logic [31:0] fpu_r_i
);
    localparam int unsigned DW  = 32;
    localparam int unsigned OPW = 2;
    localparam int unsigned CHW = 2;
    localparam int unsigned CW  = 8;

    localparam logic [OPW-1:0] OP_INV  = 2'b11;
    localparam logic [DW-1:0]  RSP_NAN = 32'h7FC0_0000;
    localparam logic [CW-1:0]  CNT_TMO = CW'(TIMEOUT);
    localparam logic [CW-1:0]  CNT_MIN = CW'(2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic            ch_q, ch_d;
    logic            last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   fpu_a_q, fpu_a_d;
    logic [DW-1:0]   fpu_b_q, fpu_b_d;
    logic [OPW-1:0]  fpu_op_q, fpu_op_d;
    logic            fpu_start_q, fpu_start_d;
    logic [CHW-1:0]  gnt_q, gnt_d;
    logic [CHW-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_r_q, rsp_r_d;
    logic            rsp_err_q, rsp_err_d;
    logic            busy_q, busy_d;

    logic            win;
    logic [OPW-1:0]  op_sel;
    logic [CW-1:0]   count;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        fpu_a_d     = fpu_a_q;
        fpu_b_d     = fpu_b_q;
        fpu_op_d    = fpu_op_q;
        fpu_start_d = 1'b0;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_r_d     = rsp_r_q;
        rsp_err_d   = rsp_err_q;
        count       = cnt_q + CW'(1);

        // On a tie the channel that was not served last wins
        if (req_i == 2'b11) begin
            win = ~last_q;
        end else begin
            win = req_i[1];
        end
        op_sel = win ? op1_i : op0_i;

        case (state_q)
            S_IDLE: begin
                if (req_i != 2'b00) begin
                    ch_d     = win;
                    gnt_d    = win ? 2'b10 : 2'b01;
                    fpu_a_d  = win ? a1_i : a0_i;
                    fpu_b_d  = win ? b1_i : b0_i;
                    fpu_op_d = op_sel;
                    if (op_sel == OP_INV) begin
                        rsp_r_d   = '0;
                        rsp_err_d = 1'b1;
                        state_d   = S_RESP;
                    end else begin
                        state_d   = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                fpu_start_d = 1'b1;
                cnt_d       = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = count;
                // A done seen on the first wait cycle is left over from a previous op
                if ((count >= CNT_MIN) && fpu_done_i) begin
                    rsp_r_d   = fpu_r_i;
                    rsp_err_d = 1'b0;
                    state_d   = S_RESP;
                end else if (count >= CNT_TMO) begin
                    rsp_r_d   = RSP_NAN;
                    rsp_err_d = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid_d = ch_q ? 2'b10 : 2'b01;
                last_d      = ch_q;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ch_q        <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            fpu_a_q     <= '0;
            fpu_b_q     <= '0;
            fpu_op_q    <= '0;
            fpu_start_q <= 1'b0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_r_q     <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            fpu_a_q     <= fpu_a_d;
            fpu_b_q     <= fpu_b_d;
            fpu_op_q    <= fpu_op_d;
            fpu_start_q <= fpu_start_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_r_q     <= rsp_r_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_r_o     = rsp_r_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = busy_q;
    assign fpu_a_o     = fpu_a_q;
    assign fpu_b_o     = fpu_b_q;
    assign fpu_op_o    = fpu_op_q;
    assign fpu_start_o = fpu_start_q;

endmodule
